// File: rtl/toggle_request_conditioner.sv
// Push-button conditioner: 2-flop synchroniser, debounce FSM, one-cycle toggle request per press.
// Optional auto-repeat while held is enabled by defining AUTOREPEAT_EN.
module toggle_request_conditioner #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int CNT_W           = 5,
  parameter int REPEAT_CYCLES   = 64
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       btn_in,
  output logic       t_out,
  output logic       btn_level,
  output logic [7:0] press_cnt
);

  typedef enum logic [1:0] {
    IDLE,
    PRESS_WAIT,
    PRESSED,
    RELEASE_WAIT
  } state_e;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  // Catch illegal parameterisations at elaboration rather than as silent misbehaviour.
  if (DEBOUNCE_CYCLES < 2 || DEBOUNCE_CYCLES > (2 ** CNT_W) - 1) begin : g_bad_debounce
    $error("DEBOUNCE_CYCLES out of range for CNT_W");
  end
  if (REPEAT_CYCLES < 2) begin : g_bad_repeat
    $error("REPEAT_CYCLES must be at least 2");
  end

  logic             s1_q, s2_q;
  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             level_q, level_d;
  logic             tout_q, tout_d;
  logic [7:0]       presscnt_q, presscnt_d;

`ifdef AUTOREPEAT_EN
  localparam int REP_W = $clog2(REPEAT_CYCLES);
  localparam logic [REP_W-1:0] REP_LAST = REP_W'(REPEAT_CYCLES - 1);
  logic [REP_W-1:0] rep_q, rep_d;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      rep_q <= '0;
    end else begin
      rep_q <= rep_d;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (!rstn) begin
      s1_q       <= 1'b0;
      s2_q       <= 1'b0;
      state_q    <= IDLE;
      cnt_q      <= '0;
      level_q    <= 1'b0;
      tout_q     <= 1'b0;
      presscnt_q <= 8'd0;
    end else begin
      s1_q       <= btn_in;
      s2_q       <= s1_q;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      level_q    <= level_d;
      tout_q     <= tout_d;
      presscnt_q <= presscnt_d;
    end
  end

  // The counter holds the number of consecutive samples seen that disagree with btn_level.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    level_d    = level_q;
    tout_d     = 1'b0;
    presscnt_d = presscnt_q;
`ifdef AUTOREPEAT_EN
    rep_d      = '0;
`endif
    case (state_q)
      IDLE: begin
        if (s2_q) begin
          state_d = PRESS_WAIT;
          cnt_d   = CNT_W'(1);
        end
      end
      PRESS_WAIT: begin
        if (!s2_q) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d    = PRESSED;
          cnt_d      = '0;
          level_d    = 1'b1;
          tout_d     = 1'b1;
          presscnt_d = presscnt_q + 8'd1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      PRESSED: begin
        if (!s2_q) begin
          state_d = RELEASE_WAIT;
          cnt_d   = CNT_W'(1);
        end
`ifdef AUTOREPEAT_EN
        else if (rep_q == REP_LAST) begin
          rep_d      = '0;
          tout_d     = 1'b1;
          presscnt_d = presscnt_q + 8'd1;
        end else begin
          rep_d = rep_q + 1'b1;
        end
`endif
      end
      RELEASE_WAIT: begin
        if (s2_q) begin
          state_d = PRESSED;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
          level_d = 1'b0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign t_out     = tout_q;
  assign btn_level = level_q;
  assign press_cnt = presscnt_q;

endmodule

// File: tb/tb_toggle_request_conditioner.sv
// Randomised and directed bench for toggle_request_conditioner against a run-length reference model.
// Define AUTOREPEAT_EN for both files to exercise the auto-repeat build.
module tb_toggle_request_conditioner;

  localparam int D     = 16;
  localparam int CNT_W = 5;
  localparam int R     = 64;

  logic       clk;
  logic       rstn;
  logic       btn_in;
  logic       t_out;
  logic       btn_level;
  logic [7:0] press_cnt;

  int checks   = 0;
  int failures = 0;
  int pulseSeen = 0;

  // Reference model state: sync pipeline, debounced level, run of disagreeing samples, hold time.
  logic       mS1 = 1'b0, mS2 = 1'b0, mLvl = 1'b0, mTout = 1'b0;
  logic [7:0] mCnt = 8'd0;
  int         mRun = 0, mHeld = 0;

  toggle_request_conditioner #(
    .DEBOUNCE_CYCLES(D),
    .CNT_W(CNT_W),
    .REPEAT_CYCLES(R)
  ) dut (
    .clk(clk),
    .rstn(rstn),
    .btn_in(btn_in),
    .t_out(t_out),
    .btn_level(btn_level),
    .press_cnt(press_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic modelPulse();
    mTout = 1'b1;
    mCnt  = mCnt + 8'd1;
  endtask

  // A level flips once D consecutive synchronised samples disagree with it; rising flips emit a pulse.
  task automatic modelStep();
    logic b;
    mTout = 1'b0;
    if (!rstn) begin
      mS1 = 1'b0; mS2 = 1'b0; mLvl = 1'b0; mCnt = 8'd0; mRun = 0; mHeld = 0;
    end else begin
      b = mS2;
      if (b == mLvl) begin
        if (mLvl && mRun == 0) begin
`ifdef AUTOREPEAT_EN
          mHeld++;
          if (mHeld == R) begin
            mHeld = 0;
            modelPulse();
          end
`endif
        end else begin
          mHeld = 0;
        end
        mRun = 0;
      end else begin
        mHeld = 0;
        mRun++;
        if (mRun == D) begin
          mLvl = b;
          mRun = 0;
          if (b) modelPulse();
        end
      end
      mS2 = mS1;
      mS1 = btn_in;
    end
  endtask

  initial begin
    forever begin
      @(posedge clk);
      modelStep();
      @(negedge clk);
      checkOutput("cyc_t_out", {7'd0, t_out}, {7'd0, mTout});
      checkOutput("cyc_btn_level", {7'd0, btn_level}, {7'd0, mLvl});
      checkOutput("cyc_press_cnt", press_cnt, mCnt);
      if (t_out === 1'b1) pulseSeen++;
    end
  end

  task automatic applyStimulus(input logic b, input int n);
    btn_in = b;
    repeat (n) @(negedge clk);
  endtask

  task automatic doReset();
    rstn   = 1'b0;
    btn_in = 1'b0;
    repeat (3) @(negedge clk);
    rstn = 1'b1;
  endtask

  initial begin
    int expRepeat;
    rstn   = 1'b0;
    btn_in = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("reset_t_out", {7'd0, t_out}, 8'd0);
    checkOutput("reset_level", {7'd0, btn_level}, 8'd0);
    checkOutput("reset_cnt", press_cnt, 8'd0);
    rstn = 1'b1;

    // Clean press: pulse appears after edge D+1, i.e. on the (D+2)th edge.
    applyStimulus(1'b1, D + 1);
    checkOutput("press_before", {7'd0, t_out}, 8'd0);
    applyStimulus(1'b1, 1);
    checkOutput("press_pulse", {7'd0, t_out}, 8'd1);
    checkOutput("press_level", {7'd0, btn_level}, 8'd1);
    checkOutput("press_cnt", press_cnt, 8'd1);
    applyStimulus(1'b1, 1);
    checkOutput("press_after", {7'd0, t_out}, 8'd0);

    // Bounce during the held press, then clean release: no extra pulse.
    applyStimulus(1'b0, 5);
    applyStimulus(1'b1, 10);
    checkOutput("bounce_level", {7'd0, btn_level}, 8'd1);
    applyStimulus(1'b0, 20);
    checkOutput("release_level", {7'd0, btn_level}, 8'd0);
    checkOutput("release_cnt", press_cnt, 8'd1);

    // Short glitch is rejected.
    doReset();
    applyStimulus(1'b1, 10);
    applyStimulus(1'b0, 20);
    checkOutput("glitch_level", {7'd0, btn_level}, 8'd0);
    checkOutput("glitch_cnt", press_cnt, 8'd0);

    // Reset mid-press with the button still held restarts the debounce.
    doReset();
    applyStimulus(1'b1, 10);
    rstn = 1'b0;
    applyStimulus(1'b1, 1);
    checkOutput("midrst_t_out", {7'd0, t_out}, 8'd0);
    checkOutput("midrst_level", {7'd0, btn_level}, 8'd0);
    checkOutput("midrst_cnt", press_cnt, 8'd0);
    rstn = 1'b1;
    applyStimulus(1'b1, D + 1);
    checkOutput("midrst_before", {7'd0, t_out}, 8'd0);
    applyStimulus(1'b1, 1);
    checkOutput("midrst_pulse", {7'd0, t_out}, 8'd1);
    checkOutput("midrst_pcnt", press_cnt, 8'd1);

    // Auto-repeat: held 200 cycles after the accept.
    applyStimulus(1'b1, 200);
`ifdef AUTOREPEAT_EN
    expRepeat = 4;
`else
    expRepeat = 1;
`endif
    checkOutput("hold_cnt", press_cnt, 8'(expRepeat));
    applyStimulus(1'b0, 25);

    // 257 clean press/release pairs wrap the counter to 1.
    doReset();
    pulseSeen = 0;
    for (int i = 0; i < 257; i++) begin
      applyStimulus(1'b1, 25);
      applyStimulus(1'b0, 25);
    end
    checkOutput("wrap_cnt", press_cnt, 8'd1);
    checks++;
    if (pulseSeen != 257) begin
      failures++;
      $display("[TB] FAIL wrap_pulses actual=%0d expected=257", pulseSeen);
    end

    // Random bouncing segments with occasional resets, checked every cycle by the model.
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 29) == 0) begin
        rstn = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
      end
      if ($urandom_range(0, 3) == 0)
        applyStimulus(1'($urandom_range(0, 1)), $urandom_range(D, 3 * D));
      else
        applyStimulus(1'($urandom_range(0, 1)), $urandom_range(1, D + 4));
    end

    @(posedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/toggle_request_conditioner.md
Name: toggle_request_conditioner

Overview:
- Upstream conditioner for the toggle flip-flop stage.
- Takes a raw, asynchronous, bouncing push-button level, then synchronises and debounces it.
- Emits exactly one single-cycle toggle request per accepted press on t_out, which drives the flip-flop's toggle input directly.
- Also exports the debounced level and a wrap-around count of accepted requests for status/debug.

Parameters:
- DEBOUNCE_CYCLES, 16: consecutive stable synchronised samples required to accept a level change; legal range 2..2^CNT_W-1.
- CNT_W, 5: width of the debounce counter; must hold DEBOUNCE_CYCLES.
- REPEAT_CYCLES, 64: held-press cycles between auto-repeat requests; used only with AUTOREPEAT_EN; minimum 2.

Ports:
- clk, input, 1: system clock; all state updates on rising edge.
- rstn, input, 1: reset.
- btn_in, input, 1: raw button level, active-high, asynchronous to clk, may bounce.
- t_out, output, 1: toggle request, one-cycle pulse; connects to flip-flop t.
- btn_level, output, 1: debounced button level.
- press_cnt, output, 8: count of t_out pulses issued, wraps 255->0.

Behaviour:
- Interface: reset rstn, synchronous, active-low; clock clk.
- Reset values: sync flops 0, state IDLE, debounce counter 0, t_out 0, btn_level 0, press_cnt 0. Reset dominates every other event.
- Synchroniser: two-flop chain btn_in -> s1 -> s2. Only s2 is used by the logic.
- FSM states:
  - IDLE: btn_level=0.
  - PRESS_WAIT: counting high samples.
  - PRESSED: btn_level=1.
  - RELEASE_WAIT: counting low samples.
- IDLE:
  - s2=1: go to PRESS_WAIT, cnt<=1.
  - Otherwise stay.
- PRESS_WAIT:
  - s2=0: go to IDLE, cnt<=0 (glitch rejected, no pulse).
  - s2=1 and cnt<DEBOUNCE_CYCLES-1: cnt<=cnt+1.
  - s2=1 and cnt==DEBOUNCE_CYCLES-1: go to PRESSED, cnt<=0, btn_level<=1, t_out<=1, press_cnt<=press_cnt+1.
- PRESSED:
  - s2=0: go to RELEASE_WAIT, cnt<=1.
  - Otherwise stay.
- RELEASE_WAIT:
  - s2=1: go to PRESSED, cnt<=0.
  - s2=0 and cnt<DEBOUNCE_CYCLES-1: cnt<=cnt+1.
  - s2=0 and cnt==DEBOUNCE_CYCLES-1: go to IDLE, btn_level<=0, cnt<=0.
  - Release never produces t_out.
- t_out: registered, high for exactly one cycle per accept, 0 on every other cycle. Back-to-back pulses are impossible, since re-arming needs at least 2*DEBOUNCE_CYCLES cycles.
- Latency: btn_in held high before edge 0 gives s2=1 after edge 1. FSM samples s2=1 at edges 2..D+1, so t_out=1 and btn_level=1 after edge D+1 (D=DEBOUNCE_CYCLES); t_out=0 after edge D+2.
- press_cnt: 8-bit modulo arithmetic, incremented in the same cycle t_out is set.
- Reset mid-operation: all state is cleared. If the button is still held after reset release, it is treated as a new press and needs the full debounce before t_out fires.

Optional Feature:
- Macro: AUTOREPEAT_EN.
- Defined:
  - A repeat counter (width sufficient for REPEAT_CYCLES) clears on entry to PRESSED and increments each cycle in PRESSED.
  - At REPEAT_CYCLES-1 it wraps to 0, pulses t_out for one cycle and increments press_cnt.
  - The counter clears on any exit from PRESSED. RELEASE_WAIT->PRESSED re-entry restarts it from 0.
- Undefined: no repeat counter exists; PRESSED emits nothing while held.

Test Plan:
- D=16, btn_in 0->1 held clean: t_out high only after edge 17; btn_level=1; press_cnt=1.
- btn_in high for 10 cycles then low: no t_out; btn_level stays 0; press_cnt=0.
- After an accepted press, btn_in bounces low for 5 cycles, then high, then released clean for 20 cycles: no extra pulse; btn_level returns to 0 after release debounce; press_cnt=1.
- rstn low for 1 cycle at cycle 10 of a held press, button still held: all outputs 0. Then t_out fires D+2 cycles after rstn returns high; press_cnt=1.
- 257 clean press/release pairs: press_cnt=1 after wrap; exactly 257 t_out pulses counted.
- AUTOREPEAT_EN, REPEAT_CYCLES=64, held 200 cycles after accept: initial pulse plus repeats every 64 cycles (3 repeats); press_cnt=4. Without the macro, press_cnt=1.
